// File: rtl/capture_write_if.sv
// Probe/configuration inputs and sample-memory write port of the logic
// analyzer capture controller, bundled so the controller and its host share one bus.
interface capture_write_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  // There is no valid/ready pair and no back-pressure. mem_we qualifies
  // waddr/mem_wdata: the memory must store mem_wdata at waddr on every rising
  // clk edge where mem_we=1. arm is a single-cycle request. The controller
  // samples it only in IDLE or DONE and ignores it while a capture is running.
  logic                  arm;
  logic [DATA_WIDTH-1:0] sample_in;
  logic [DATA_WIDTH-1:0] trigger_mask;
  logic [DATA_WIDTH-1:0] trigger_value;
  logic [ADDR_WIDTH-1:0] post_trigger_count;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic                  triggered;
  logic                  done;

  modport master (
    output arm, sample_in, trigger_mask, trigger_value, post_trigger_count,
    input  mem_we, waddr, mem_wdata, trig_addr, triggered, done
  );

  modport slave (
    input  arm, sample_in, trigger_mask, trigger_value, post_trigger_count,
    output mem_we, waddr, mem_wdata, trig_addr, triggered, done
  );
endinterface

// File: rtl/capture_write.sv
// Write side of the circular sample buffer: prefill, wait for the masked trigger,
// keep P post-trigger samples, then park waddr on the oldest sample.
module capture_write #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int MEMORY_SIZE = 2**ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  capture_write_if.slave bus,
  output logic [2:0]   dbg_state
);
  typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEMORY_SIZE - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                  triggered_q, triggered_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] p_q, p_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  mem_we;
  logic                  match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      cnt_q       <= '0;
      p_q         <= '0;
      mask_q      <= '0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
    end
  end

  // Trigger settings are latched on arm so host-side changes cannot disturb a running capture.
  assign match = ((bus.sample_in ^ value_q) & mask_q) == '0;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    mask_d      = mask_q;
    value_d     = value_q;
    mem_we      = (state_q == PREFILL) || (state_q == ARMED) || (state_q == POST);

    if (mem_we) waddr_d = waddr_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (bus.arm) begin
          waddr_d     = '0;
          p_d         = bus.post_trigger_count;
          mask_d      = bus.trigger_mask;
          value_d     = bus.trigger_value;
          triggered_d = 1'b0;
          cnt_d       = '0;
          // Pre-trigger depth D = LAST - P; D == 0 means no prefill at all.
          state_d     = ((LAST - bus.post_trigger_count) != '0) ? PREFILL : ARMED;
        end
      end
      PREFILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == (LAST - p_q)) state_d = ARMED;
      end
      ARMED: begin
        if (match) begin
          trig_addr_d = waddr_q;
          triggered_d = 1'b1;
          cnt_d       = '0;
          state_d     = (p_q != '0) ? POST : DONE;
        end
      end
      POST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == p_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_we    = mem_we;
  assign bus.waddr     = waddr_q;
  assign bus.mem_wdata = bus.sample_in;
  assign bus.trig_addr = trig_addr_q;
  assign bus.triggered = triggered_q;
  assign bus.done      = (state_q == DONE);
  assign dbg_state     = state_q;
endmodule

// File: doc/capture_write.md
# capture_write

Write-side controller for the internal logic analyzer's circular sample buffer. After an arm pulse it streams one probe sample per clock into the sample memory, evaluates a masked trigger, and stops after a programmed number of post-trigger samples. On completion its write pointer addresses the oldest stored sample, so the read side can start reading there and walk the buffer in order.

## Interface
- DATA_WIDTH, 8, probe sample width
- ADDR_WIDTH, 4, buffer address width
- MEMORY_SIZE, 2**ADDR_WIDTH, buffer depth in samples
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- arm  in  1  start capture; honoured only in IDLE or DONE
- sample_in  in  DATA_WIDTH  probe data, sampled every cycle
- trigger_mask  in  DATA_WIDTH  1 = bit participates in compare
- trigger_value  in  DATA_WIDTH  compare value
- post_trigger_count  in  ADDR_WIDTH  samples kept after trigger (P), latched on arm
- mem_we  out  1  memory write strobe
- waddr  out  ADDR_WIDTH  write pointer; after DONE, address of oldest sample
- mem_wdata  out  DATA_WIDTH  equals sample_in, combinational pass-through
- trig_addr  out  ADDR_WIDTH  address where the trigger sample was written
- triggered  out  1  trigger seen in current capture
- done  out  1  capture complete, buffer stable

## Operation
- States: IDLE, PREFILL, ARMED, POST, DONE.
- Pre-trigger depth D = MEMORY_SIZE-1-P, computed from latched P.
- mem_we decoded from state register only: 1 in PREFILL, ARMED and POST, else 0. The memory writes mem_wdata at waddr on the clock edge when mem_we=1.
- Every write cycle: waddr <= waddr+1, modulo MEMORY_SIZE with natural wrap.
- IDLE/DONE + arm: waddr<=0, latch P, clear triggered/done/counter; next state PREFILL if D>0, else ARMED.
- PREFILL: counter counts writes. The write that makes count==D moves to ARMED.
- ARMED: match = ((sample_in ^ trigger_value) & trigger_mask)==0, evaluated on the sample written this cycle. ARMED writes continue and wrap indefinitely until match.
  - On match: trig_addr<=waddr, triggered<=1, counter<=0.
  - Next state POST if P>0, else DONE.
- trigger_mask=0 matches on the first ARMED cycle.
- POST: the write that makes count==P moves to DONE.
- DONE: no writes; done=1; waddr, trig_addr and triggered hold. waddr = trig_addr+P+1 mod MEMORY_SIZE, which is the oldest sample.
- arm in PREFILL/ARMED/POST is ignored. trigger_* and post_trigger_count changes outside an arm cycle have no effect on the active capture.
- Reset, at any time including mid-capture: state IDLE; waddr, trig_addr, triggered, done all 0; mem_we 0 from the cycle after reset is sampled.

## Timing
- Arm sampled at edge k; first write on edge k+1, at address 0.
- Trigger sample written on the match edge. triggered and trig_addr are visible the cycle after.
- Minimum capture from arm: MEMORY_SIZE writes (ARMED lasts one cycle). Total writes = D + (ARMED cycles) + P.
- done rises the cycle after the last POST write, or after the match write when P=0.
- Reset values: all outputs 0 (mem_wdata follows sample_in).

## Test plan
- Reset: assert reset 2 cycles while driving arm -> mem_we=0, waddr=0, trig_addr=0, triggered=0, done=0.
- ADDR_WIDTH=4, P=5, mask=0x0F, value=0x0C, sample_in=0x00,0x01,... from the first write cycle -> 0x00..0x09 written at addresses 0..9. 0x0C triggers at address 12, so trig_addr=12. 0x0D..0x11 written at addresses 13,14,15,0,1. done=1, waddr=2, mem[2]=0x02, 18 writes total.
- P=0, mask=0 -> 15 PREFILL writes, trigger at address 15. done with waddr=0, trig_addr=15, exactly 16 writes.
- P=15, mask=0 -> arm goes straight to ARMED. Trigger at address 0, then 15 POST writes; waddr=0, trig_addr=0.
- Reset pulse in POST -> next cycle mem_we=0 and all outputs 0. Re-arm runs a full correct capture.
- arm pulsed in ARMED -> ignored; waddr keeps incrementing. arm in DONE -> done drops next cycle and waddr restarts at 0.
